// File: rtl/bcd_convert_seq_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_convert_seq_pkg;

  localparam int unsigned BCD_DIGIT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Counter must hold the value WIDTH itself, hence the extra bit.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/bcd_dabble_digit.sv
// One double-dabble correction cell: a BCD digit of 5 or more gets 3 added before the shift.
module bcd_dabble_digit
  import bcd_convert_seq_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] din,
  output logic [BCD_DIGIT_W-1:0] dout_c
);

  always_comb begin
    dout_c = din;
    if (din >= BCD_DIGIT_W'(5)) begin
      dout_c = din + BCD_DIGIT_W'(3);
    end
  end

endmodule

// File: rtl/bcd_convert_seq.sv
// Iterative signed/unsigned binary-to-BCD converter, one input bit per clock,
// with start/done handshake, sign extraction and range-overflow detection.
module bcd_convert_seq
  import bcd_convert_seq_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          signed_mode,
  input  logic [WIDTH-1:0]              bin_in,
  output logic                          busy,
  output logic                          done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out,
  output logic                          neg,
  output logic                          ovf
);

  localparam int unsigned ACC_W = BCD_DIGIT_W * DIGITS;
  localparam int unsigned CNT_W = cnt_width(WIDTH);

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   mag_q, mag_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sign_q, sign_d;
  logic               ovf_acc_q, ovf_acc_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [ACC_W-1:0]   bcd_q, bcd_d;
  logic               neg_q, neg_d;
  logic               ovf_q, ovf_d;

  logic [ACC_W-1:0]   acc_adj_c;
  logic               sign_c;

  // Add-3 correction on every digit, ahead of this cycle's shift.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    bcd_dabble_digit u_digit (
      .din    (acc_q[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .dout_c (acc_adj_c[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  assign sign_c = signed_mode & bin_in[WIDTH-1];

  // Next-state, datapath and output register logic.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mag_d     = mag_q;
    cnt_d     = cnt_q;
    sign_d    = sign_q;
    ovf_acc_d = ovf_acc_q;
    done_d    = 1'b0;
    bcd_d     = bcd_q;
    neg_d     = neg_q;
    ovf_d     = ovf_q;
    // busy lags the state by one cycle, so it stays high through the done cycle.
    busy_d    = (state_q != ST_IDLE);

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          sign_d    = sign_c;
          mag_d     = sign_c ? WIDTH'(~bin_in + WIDTH'(1)) : bin_in;
          acc_d     = '0;
          ovf_acc_d = 1'b0;
          cnt_d     = '0;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        acc_d     = {acc_adj_c[ACC_W-2:0], mag_q[WIDTH-1]};
        mag_d     = {mag_q[WIDTH-2:0], 1'b0};
        ovf_acc_d = ovf_acc_q | acc_adj_c[ACC_W-1];
        cnt_d     = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        bcd_d   = acc_q;
        neg_d   = sign_q;
        ovf_d   = ovf_acc_q;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      mag_q     <= '0;
      cnt_q     <= '0;
      sign_q    <= 1'b0;
      ovf_acc_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bcd_q     <= '0;
      neg_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mag_q     <= mag_d;
      cnt_q     <= cnt_d;
      sign_q    <= sign_d;
      ovf_acc_q <= ovf_acc_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      bcd_q     <= bcd_d;
      neg_q     <= neg_d;
      ovf_q     <= ovf_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign bcd_out = bcd_q;
  assign neg     = neg_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_bcd_convert_seq.sv
// Randomized self-checking bench: a 3-digit and a 2-digit converter against a decimal reference model.
module tb_bcd_convert_seq;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start_a, start_b;
  logic             signed_mode;
  logic [WIDTH-1:0] bin_in;

  logic        busy_a, done_a, neg_a, ovf_a;
  logic [11:0] bcd_a;
  logic        busy_b, done_b, neg_b, ovf_b;
  logic [7:0]  bcd_b;

  int          sel;
  logic        busy_s, done_s, neg_s, ovf_s;
  logic [11:0] bcd_s;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  bcd_convert_seq #(.WIDTH(WIDTH), .DIGITS(3)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .signed_mode(signed_mode), .bin_in(bin_in),
    .busy(busy_a), .done(done_a), .bcd_out(bcd_a), .neg(neg_a), .ovf(ovf_a)
  );

  bcd_convert_seq #(.WIDTH(WIDTH), .DIGITS(2)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .signed_mode(signed_mode), .bin_in(bin_in),
    .busy(busy_b), .done(done_b), .bcd_out(bcd_b), .neg(neg_b), .ovf(ovf_b)
  );

  always_comb begin
    if (sel == 0) begin
      busy_s = busy_a; done_s = done_a; bcd_s = bcd_a;          neg_s = neg_a; ovf_s = ovf_a;
    end else begin
      busy_s = busy_b; done_s = done_b; bcd_s = {4'h0, bcd_b}; neg_s = neg_b; ovf_s = ovf_b;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Decimal reference: signed value -> sign, magnitude, low decimal digits, range check.
  function automatic void ref_model(input logic [7:0] b, input logic sm, input int digits,
                                    output logic [11:0] bcd, output logic n, output logic o);
    int v, mag, lim;
    v   = (sm && b[7]) ? int'(b) - 256 : int'(b);
    n   = (v < 0);
    mag = n ? -v : v;
    lim = 1;
    for (int i = 0; i < digits; i++) lim = lim * 10;
    o   = (mag >= lim);
    bcd = '0;
    for (int i = 0; i < digits; i++) begin
      bcd[4*i +: 4] = 4'(mag % 10);
      mag = mag / 10;
    end
  endfunction

  // Called #1 after a rising edge with the selected DUT idle.
  task automatic convert(input int which, input logic [7:0] b, input logic sm, input string tag);
    logic [11:0] eb;
    logic        en, eo;
    int          lat;
    ref_model(b, sm, (which == 0) ? 3 : 2, eb, en, eo);
    sel = which; bin_in = b; signed_mode = sm;
    if (which == 0) start_a = 1'b1; else start_b = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (n == 1) check({tag, " busy_early"}, 32'(busy_s), 32'd1);
      if (done_s) begin
        lat = n;
        break;
      end
    end
    check({tag, " latency"}, 32'(lat), 32'(WIDTH + 1));
    check({tag, " bcd"}, 32'(bcd_s), 32'(eb));
    check({tag, " neg"}, 32'(neg_s), 32'(en));
    check({tag, " ovf"}, 32'(ovf_s), 32'(eo));
    @(posedge clk); #1;
    check({tag, " busy_after"}, 32'(busy_s), 32'd0);
    check({tag, " done_pulse"}, 32'(done_s), 32'd0);
    check({tag, " bcd_hold"}, 32'(bcd_s), 32'(eb));
  endtask

  initial begin
    int          done_cnt;
    logic [11:0] seen_bcd;
    int          done_at[$];
    logic [7:0]  rb;
    logic        rs;

    sel = 0; rst = 1'b1; start_a = 1'b0; start_b = 1'b0; signed_mode = 1'b0; bin_in = '0;
    repeat (3) @(posedge clk);
    #1;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    check("reset busy_a", 32'(busy_a), 32'd0);
    check("reset done_a", 32'(done_a), 32'd0);
    check("reset bcd_a",  32'(bcd_a),  32'd0);
    check("reset neg_a",  32'(neg_a),  32'd0);
    check("reset ovf_a",  32'(ovf_a),  32'd0);
    check("reset bcd_b",  32'(bcd_b),  32'd0);
    check("reset ovf_b",  32'(ovf_b),  32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_wins busy_a", 32'(busy_a), 32'd0);

    convert(0, 8'hFF, 1'b0, "unsigned_max");
    convert(0, 8'hF6, 1'b1, "signed_neg");
    convert(0, 8'h80, 1'b1, "signed_min");
    convert(0, 8'h80, 1'b0, "unsigned_80");

    // Second start while busy must be dropped, and the captured operand kept.
    sel = 0; bin_in = 8'h2A; signed_mode = 1'b0; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    bin_in = 8'h63; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    done_cnt = 0; seen_bcd = '0;
    for (int c = 0; c < 27; c++) begin
      @(posedge clk); #1;
      if (done_a) begin
        done_cnt++;
        seen_bcd = bcd_a;
      end
    end
    check("busy_ignore done_count", 32'(done_cnt), 32'd1);
    check("busy_ignore bcd", 32'(seen_bcd), 32'h042);

    convert(0, 8'h00, 1'b1, "signed_zero");

    // start held high: conversions every WIDTH+2 cycles.
    sel = 0; bin_in = 8'h7B; signed_mode = 1'b0; start_a = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      if (done_a) done_at.push_back(c);
    end
    start_a = 1'b0;
    check("b2b done_count", 32'(done_at.size()), 32'd3);
    if (done_at.size() == 3) begin
      check("b2b first", 32'(done_at[0]), 32'(WIDTH + 2));
      check("b2b spacing1", 32'(done_at[1] - done_at[0]), 32'(WIDTH + 2));
      check("b2b spacing2", 32'(done_at[2] - done_at[1]), 32'(WIDTH + 2));
    end
    check("b2b bcd", 32'(bcd_a), 32'h123);
    repeat (3) @(posedge clk);
    #1;

    for (int i = 0; i < 24; i++) begin
      rb = 8'($urandom);
      rs = 1'($urandom);
      convert(0, rb, rs, $sformatf("rand_a%0d", i));
    end

    convert(1, 8'd200, 1'b0, "ovf_200");
    convert(1, 8'd99, 1'b0, "fit_99");
    convert(1, 8'd100, 1'b0, "ovf_100");
    for (int i = 0; i < 10; i++) begin
      rb = 8'($urandom);
      rs = 1'($urandom);
      convert(1, rb, rs, $sformatf("rand_b%0d", i));
    end
    convert(1, 8'hF6, 1'b1, "signed_neg_b");

    // Reset four cycles into a conversion aborts it with no done pulse.
    sel = 1; bin_in = 8'd200; signed_mode = 1'b0; start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort busy", 32'(busy_b), 32'd0);
    check("abort done", 32'(done_b), 32'd0);
    check("abort bcd",  32'(bcd_b),  32'd0);
    check("abort neg",  32'(neg_b),  32'd0);
    check("abort ovf",  32'(ovf_b),  32'd0);
    rst = 1'b0;
    done_cnt = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      if (done_b) done_cnt++;
    end
    check("abort no_done", 32'(done_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
